regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between the ALU writeback stage and the variable-latency data-memory (load) writeback. It buffers load results in a 2-entry FIFO and arbitrates with a bounded-wait fairness rule. A 32-entry pending-load scoreboard tells decode when a source register still awaits a load result. It sits between the WB stage / load unit and `registerfile`, driving its `RegWrite`, `WriteReg` and `WriteData` inputs.

---
 rtl/regfile_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and load writeback,
// buffering loads in a 2-entry FIFO with bounded-wait fairness and a pending-load scoreboard.
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DW      = 64,
  parameter int AW      = 5,
  parameter int MAXWAIT = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          alu_wr_valid,
  input  logic [AW-1:0] alu_wr_reg,
  input  logic [DW-1:0] alu_wr_data,
  output logic          alu_wr_ready,
  input  logic          mem_wr_valid,
  input  logic [AW-1:0] mem_wr_reg,
  input  logic [DW-1:0] mem_wr_data,
  output logic          mem_wr_ready,
  input  logic          ld_issue_valid,
  input  logic [AW-1:0] ld_issue_reg,
  input  logic [AW-1:0] rd_reg1,
  input  logic [AW-1:0] rd_reg2,
  output logic          hazard1,
  output logic          hazard2,
  output logic          rf_write,
  output logic [AW-1:0] rf_wreg,
  output logic [DW-1:0] rf_wdata
);

  localparam int            NREG      = 1 << AW;
  localparam logic [AW-1:0] ZERO_REG  = '1;
  localparam logic [1:0]    MAXWAIT_W = 2'(MAXWAIT);

  logic [AW-1:0] fifo_reg_q  [2];
  logic [AW-1:0] fifo_reg_d  [2];
  logic [DW-1:0] fifo_data_q [2];
  logic [DW-1:0] fifo_data_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [1:0]    wait_q, wait_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic          rf_write_q, rf_write_d;
  logic [AW-1:0] rf_wreg_q, rf_wreg_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;

  logic          fifo_nonempty;
  logic          force_mem;
  logic          grant_mem;
  logic          grant_alu;
  logic          push;
  logic [AW-1:0] head_reg;
  logic [DW-1:0] head_data;

  assign fifo_nonempty = (count_q != 2'd0);
  assign force_mem     = fifo_nonempty && (wait_q >= MAXWAIT_W);
  assign alu_wr_ready  = !force_mem;
  assign mem_wr_ready  = (count_q < 2'd2);
  assign grant_mem     = fifo_nonempty && (force_mem || !alu_wr_valid);
  assign grant_alu     = alu_wr_valid && alu_wr_ready;
  assign push          = mem_wr_valid && mem_wr_ready;
  assign head_reg      = fifo_reg_q[rd_ptr_q];
  assign head_data     = fifo_data_q[rd_ptr_q];

  // The in-flight term covers the cycle where registerfile has not yet captured the write.
  assign hazard1 = busy_q[rd_reg1] || (rf_write_q && (rf_wreg_q == rd_reg1) && (rd_reg1 != ZERO_REG));
  assign hazard2 = busy_q[rd_reg2] || (rf_write_q && (rf_wreg_q == rd_reg2) && (rd_reg2 != ZERO_REG));

  assign rf_write = rf_write_q;
  assign rf_wreg  = rf_wreg_q;
  assign rf_wdata = rf_wdata_q;

  always_comb begin
    fifo_reg_d  = fifo_reg_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + {1'b0, push} - {1'b0, grant_mem};
    wait_d      = wait_q;
    busy_d      = busy_q;
    rf_write_d  = 1'b0;
    rf_wreg_d   = rf_wreg_q;
    rf_wdata_d  = rf_wdata_q;

    if (push) begin
      fifo_reg_d[wr_ptr_q]  = mem_wr_reg;
      fifo_data_d[wr_ptr_q] = mem_wr_data;
      wr_ptr_d              = ~wr_ptr_q;
    end

    if (grant_mem) begin
      rd_ptr_d         = ~rd_ptr_q;
      busy_d[head_reg] = 1'b0;
      rf_write_d       = (head_reg != ZERO_REG);
      rf_wreg_d        = head_reg;
      rf_wdata_d       = head_data;
    end else if (grant_alu) begin
      rf_write_d = (alu_wr_reg != ZERO_REG);
      rf_wreg_d  = alu_wr_reg;
      rf_wdata_d = alu_wr_data;
    end

    if (grant_mem || !fifo_nonempty) begin
      wait_d = 2'd0;
    end else if (wait_q != 2'd3) begin
      wait_d = wait_q + 2'd1;
    end

    // Applied after the clear so a same-cycle re-issue keeps the register pending.
    if (ld_issue_valid && (ld_issue_reg != ZERO_REG)) begin
      busy_d[ld_issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_reg_q  <= '{default: '0};
      fifo_data_q <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      wait_q      <= 2'd0;
      busy_q      <= '0;
      rf_write_q  <= 1'b0;
      rf_wreg_q   <= '0;
      rf_wdata_q  <= '0;
    end else begin
      fifo_reg_q  <= fifo_reg_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      rf_write_q  <= rf_write_d;
      rf_wreg_q   <= rf_wreg_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based model of the writeback arbiter.
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int MAXWAIT = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_wr_valid = 1'b0;
  logic [4:0]  alu_wr_reg = '0;
  logic [63:0] alu_wr_data = '0;
  logic        alu_wr_ready;
  logic        mem_wr_valid = 1'b0;
  logic [4:0]  mem_wr_reg = '0;
  logic [63:0] mem_wr_data = '0;
  logic        mem_wr_ready;
  logic        ld_issue_valid = 1'b0;
  logic [4:0]  ld_issue_reg = '0;
  logic [4:0]  rd_reg1 = '0;
  logic [4:0]  rd_reg2 = '0;
  logic        hazard1, hazard2;
  logic        rf_write;
  logic [4:0]  rf_wreg;
  logic [63:0] rf_wdata;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.DW(64), .AW(5), .MAXWAIT(MAXWAIT)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_wr_valid(alu_wr_valid), .alu_wr_reg(alu_wr_reg), .alu_wr_data(alu_wr_data),
    .alu_wr_ready(alu_wr_ready),
    .mem_wr_valid(mem_wr_valid), .mem_wr_reg(mem_wr_reg), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_reg(ld_issue_reg),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_write(rf_write), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic [4:0]  r;
    logic [63:0] d;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // Reference model: load queue, loss counter, pending set, and the last write issued.
  ent_t        fq[$];
  int          m_wait;
  bit          m_busy[32];
  bit          m_write;
  logic [4:0]  m_wreg;
  logic [63:0] m_wdata;

  logic s_alu_ready, s_mem_ready, last_ga, last_push;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_wait = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_write = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
  endtask

  function automatic bit exp_hazard(input logic [4:0] r);
    return (r != 5'd31) && (m_busy[r] || (m_write && m_wreg == r));
  endfunction

  task automatic step(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                      input logic mv, input logic [4:0] mr, input logic [63:0] md,
                      input logic li, input logic [4:0] lr,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit   ne, frc, gm, ga, pu;
    ent_t h;
    ent_t n;
    @(negedge clock);
    alu_wr_valid = av; alu_wr_reg = ar; alu_wr_data = ad;
    mem_wr_valid = mv; mem_wr_reg = mr; mem_wr_data = md;
    ld_issue_valid = li; ld_issue_reg = lr;
    rd_reg1 = r1; rd_reg2 = r2;
    #1;
    ne  = fq.size() > 0;
    frc = ne && (m_wait >= MAXWAIT);
    gm  = ne && (frc || !av);
    ga  = av && !frc;
    pu  = mv && (fq.size() < 2);
    chk("alu_wr_ready", alu_wr_ready, !frc);
    chk("mem_wr_ready", mem_wr_ready, fq.size() < 2);
    chk("hazard1", hazard1, exp_hazard(r1));
    chk("hazard2", hazard2, exp_hazard(r2));
    chk("rf_write", rf_write, m_write);
    chk("rf_wreg", rf_wreg, m_wreg);
    chk("rf_wdata", rf_wdata, m_wdata);
    s_alu_ready = alu_wr_ready;
    s_mem_ready = mem_wr_ready;
    last_ga = ga;
    last_push = pu;
    if (gm) begin
      h = fq.pop_front();
      m_write = (h.r != 5'd31);
      m_wreg  = h.r;
      m_wdata = h.d;
      m_busy[h.r] = 1'b0;
    end else if (ga) begin
      m_write = (ar != 5'd31);
      m_wreg  = ar;
      m_wdata = ad;
    end else begin
      m_write = 1'b0;
    end
    if (pu) begin
      n.r = mr;
      n.d = md;
      fq.push_back(n);
    end
    m_wait = (gm || !ne) ? 0 : ((m_wait < 3) ? m_wait + 1 : 3);
    if (li && lr != 5'd31) m_busy[lr] = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse landing between clock edges; outputs must clear at once.
  task automatic async_reset(input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clock);
    #2;
    alu_wr_valid = 0; mem_wr_valid = 0; ld_issue_valid = 0;
    rd_reg1 = r1; rd_reg2 = r2;
    reset_n = 1'b0;
    #1;
    chk("rst_rf_write", rf_write, 1'b0);
    chk("rst_rf_wreg", rf_wreg, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 64'd0);
    chk("rst_mem_ready", mem_wr_ready, 1'b1);
    chk("rst_alu_ready", alu_wr_ready, 1'b1);
    chk("rst_hazard1", hazard1, 1'b0);
    chk("rst_hazard2", hazard2, 1'b0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic        av, mv, li;
    logic [4:0]  ar, mr, lr, r1, r2;
    logic [63:0] ad, md;

    model_reset();
    repeat (2) @(negedge clock);
    #1;
    chk("init_rf_write", rf_write, 1'b0);
    chk("init_rf_wreg", rf_wreg, 5'd0);
    chk("init_rf_wdata", rf_wdata, 64'd0);
    chk("init_mem_ready", mem_wr_ready, 1'b1);
    chk("init_alu_ready", alu_wr_ready, 1'b1);
    chk("init_hazard1", hazard1, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);

    // ALU write to x5
    step(1, 5, 64'h1234, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_x5_ready", s_alu_ready, 1'b1);
    chk("alu_x5_write", rf_write, 1'b1);
    chk("alu_x5_wreg", rf_wreg, 5'd5);
    chk("alu_x5_wdata", rf_wdata, 64'h1234);
    idle(1);

    // Load to x7 and its hazard window
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    chk("ld7_haz_issue", hazard1, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 1, 7, 64'hDEAD, 0, 0, 7, 0);
    chk("ld7_haz_pushed", hazard1, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("ld7_write", rf_write, 1'b1);
    chk("ld7_wreg", rf_wreg, 5'd7);
    chk("ld7_wdata", rf_wdata, 64'hDEAD);
    chk("ld7_haz_inflight", hazard1, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("ld7_haz_clear", hazard1, 1'b0);
    chk("ld7_write_one", rf_write, 1'b0);
    idle(2);

    // Fairness: ALU always valid, one load waiting
    step(1, 1, 64'h11, 1, 2, 64'h22, 0, 0, 0, 0);
    chk("fair_r1", s_alu_ready, 1'b1);
    step(1, 3, 64'h33, 0, 0, 0, 0, 0, 0, 0);
    chk("fair_r2", s_alu_ready, 1'b1);
    step(1, 4, 64'h44, 0, 0, 0, 0, 0, 0, 0);
    chk("fair_r3", s_alu_ready, 1'b1);
    step(1, 5, 64'h55, 0, 0, 0, 0, 0, 0, 0);
    chk("fair_forced", s_alu_ready, 1'b0);
    chk("fair_ld_wreg", rf_wreg, 5'd2);
    chk("fair_ld_wdata", rf_wdata, 64'h22);
    step(1, 5, 64'h55, 0, 0, 0, 0, 0, 0, 0);
    chk("fair_resume", s_alu_ready, 1'b1);
    chk("fair_alu_wdata", rf_wdata, 64'h55);
    idle(3);

    // Three loads back-to-back while ALU is busy
    step(1, 8, 64'h80, 1, 10, 64'hA0, 0, 0, 0, 0);
    step(1, 9, 64'h90, 1, 11, 64'hB0, 0, 0, 0, 0);
    step(1, 12, 64'hC0, 1, 13, 64'hD0, 0, 0, 0, 0);
    chk("full_ready0", s_mem_ready, 1'b0);
    step(1, 14, 64'hE0, 1, 13, 64'hD0, 0, 0, 0, 0);
    chk("full_ready_pop", s_mem_ready, 1'b0);
    step(1, 14, 64'hE0, 1, 13, 64'hD0, 0, 0, 0, 0);
    chk("full_ready_after", s_mem_ready, 1'b1);
    for (int i = 0; i < 6; i++) step(1, 5'(16 + i), 64'(i), 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Register 31 traffic
    step(1, 31, 64'hF00D, 0, 0, 0, 0, 0, 31, 31);
    chk("x31_alu_ready", s_alu_ready, 1'b1);
    chk("x31_alu_nowrite", rf_write, 1'b0);
    step(0, 0, 0, 1, 31, 64'hBEEF, 1, 31, 31, 31);
    chk("x31_mem_ready", s_mem_ready, 1'b1);
    chk("x31_haz_issue", hazard1, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 31, 31);
    chk("x31_ld_nowrite", rf_write, 1'b0);
    chk("x31_haz_after", hazard2, 1'b0);
    idle(2);

    // Reset with two loads buffered and pending marks set
    step(1, 1, 64'h1, 1, 9, 64'h99, 1, 9, 9, 10);
    step(1, 2, 64'h2, 1, 10, 64'hAA, 1, 10, 9, 10);
    chk("pre_rst_haz", hazard2, 1'b1);
    async_reset(9, 10);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 9, 10);
      chk("post_rst_nowrite", rf_write, 1'b0);
    end

    // Randomized traffic honouring the valid/ready hold rule
    av = 0; mv = 0; ar = 0; mr = 0; ad = 0; md = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        async_reset(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        av = 0; mv = 0;
      end
      if (!(av && !last_ga)) begin
        av = ($urandom_range(0, 99) < 60);
        ar = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
        ad = {$urandom, $urandom};
      end
      if (!(mv && !last_push)) begin
        mv = ($urandom_range(0, 99) < 40);
        mr = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
        md = {$urandom, $urandom};
      end
      li = ($urandom_range(0, 99) < 30);
      lr = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
      r1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
      r2 = 5'($urandom_range(0, 31));
      step(av, ar, ad, mv, mr, md, li, lr, r1, r2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
